// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: circular byte FIFO that launches one UART frame at a time and waits for tx_done.
// Optional handshake watchdog is compiled in with `define UART_TX_BUF_TIMEOUT_EN.
module uart_tx_buffer #(
   parameter int DEPTH          = 16,
   parameter int AW             = 4,
   parameter int TIMEOUT_CYCLES = 120000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          clr_overflow,
   output logic          busy,
   output logic          uart_start,
   output logic [7:0]    uart_data,
   input  logic          uart_tx_done,
   output logic          tx_timeout
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          start_q, start_d;
   logic [7:0]    data_q, data_d;
   logic          push, launch, done_ok, timeout_hit;

   assign full   = (count_q == (AW+1)'(DEPTH));
   assign empty  = (count_q == '0);
   assign push   = wr_en && !full;
   assign launch = (state_q == S_IDLE) && !empty;
   // start_q is high exactly on the first WAIT cycle, where tx_done must be ignored
   assign done_ok = (state_q == S_WAIT) && uart_tx_done && !start_q;

`ifdef UART_TX_BUF_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmr_q, tmr_d;
   logic          tx_timeout_q, tx_timeout_d;

   assign timeout_hit = (state_q == S_WAIT) && !done_ok && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmr_d = tmr_q;
      if (launch) begin
         tmr_d = '0;
      end else if (state_q == S_WAIT) begin
         tmr_d = tmr_q + 1'b1;
      end
      tx_timeout_d = tx_timeout_q | timeout_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_q        <= '0;
         tx_timeout_q <= 1'b0;
      end else begin
         tmr_q        <= tmr_d;
         tx_timeout_q <= tx_timeout_d;
      end
   end

   assign tx_timeout = tx_timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_hit        = 1'b0;
   assign tx_timeout         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (launch) state_d = S_WAIT;
         S_WAIT: if (done_ok || timeout_hit) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_d = launch;
      data_d  = launch ? mem_q[rd_ptr_q] : data_q;
   end

   // FIFO bookkeeping; a write and a launch on the same edge leave count unchanged
   always_comb begin
      wr_ptr_d = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = launch ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, launch})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (wr_en && full) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         start_q    <= 1'b0;
         data_q     <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         start_q    <= start_d;
         data_q     <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign count      = count_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q == S_WAIT);
   assign uart_start = start_q;
   assign uart_data  = data_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: randomized traffic against a queue-based reference model.
module tb_uart_tx_buffer;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int TO    = 50;
`ifdef UART_TX_BUF_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en = 1'b0, clr_overflow = 1'b0, uart_tx_done = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          full, empty, overflow, busy, uart_start, tx_timeout;
   logic [AW:0]   count;
   logic [7:0]    uart_data;

   always #5 clk = ~clk;

   uart_tx_buffer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .clr_overflow(clr_overflow), .busy(busy), .uart_start(uart_start),
      .uart_data(uart_data), .uart_tx_done(uart_tx_done), .tx_timeout(tx_timeout)
   );

   // reference model: bytes waiting in the buffer, plus the frame currently on the wire
   logic [7:0] m_fifo[$];
   logic [7:0] got[$];
   bit         m_busy, m_first, m_ovf, m_to;
   logic [7:0] m_data;
   int         m_wait;
   int         checks = 0, failures = 0, cyc = 0, last_done_cyc = -100;
   bit         tx_auto;
   int         tx_cnt, dly_lo = 1, dly_hi = 5;

   wire [18:0] dut_vec = {count, full, empty, overflow, busy, uart_start, uart_data, tx_timeout};

   function automatic logic [18:0] exp_vec();
      int n = m_fifo.size();
      return {5'(n), (n == DEPTH), (n == 0), m_ovf, m_busy, m_first, m_data, m_to};
   endfunction

   task automatic model_reset();
      m_fifo.delete();
      m_busy = 0; m_first = 0; m_ovf = 0; m_to = 0; m_data = 8'h00; m_wait = 0;
      tx_cnt = 0; tx_auto = 0;
   endtask

   task automatic do_reset();
      wr_en = 0; clr_overflow = 0; uart_tx_done = 0; wr_data = 8'h00;
      rst_n = 1'b0;
      model_reset();
      got.delete();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // advance one clock: update the model from the pre-edge inputs, then play the transmitter
   task automatic tick();
      bit pop, push, done_eff;
      logic [7:0] wd;
      pop      = !m_busy && (m_fifo.size() != 0);
      push     = wr_en && (m_fifo.size() != DEPTH);
      done_eff = uart_tx_done && m_busy && !m_first;
      wd       = wr_data;
      if (uart_tx_done) last_done_cyc = cyc;
      if (wr_en && m_fifo.size() == DEPTH) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
      if (pop) begin
         m_data = m_fifo.pop_front();
         m_busy = 1; m_first = 1; m_wait = 0;
      end else if (m_busy) begin
         m_first = 0;
         m_wait++;
         if (done_eff) m_busy = 0;
         else if (TO_EN && m_wait == TO) begin m_busy = 0; m_to = 1; end
      end
      if (push) m_fifo.push_back(wd);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (uart_start === 1'b1) got.push_back(uart_data);
      uart_tx_done = 1'b0;
      if (tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 0) uart_tx_done = 1'b1;
      end
      if (tx_auto && m_first) tx_cnt = $urandom_range(dly_hi, dly_lo);
   endtask

   task automatic test_reset();
      do_reset();
      wr_en = 1; wr_data = 8'h3C; tick(); tick(); tick();
      rst_n = 1'b0; model_reset();
      #1;
      checks++;
      if (dut_vec !== 19'b00000_0_1_0_0_0_00000000_0) begin
         failures++; $display("FAIL reset_async got=%h exp=%h", dut_vec, 19'b00000_0_1_0_0_0_00000000_0);
      end
      wr_en = 0;
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
         failures++; $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_single();
      do_reset();
      uart_tx_done = 1; tick();  // done while idle must be ignored
      uart_tx_done = 0;
      wr_en = 1; wr_data = 8'h55; tick(); wr_en = 0;
      checks++;
      if (uart_start !== 1'b0 || count !== 5'd1) begin
         failures++; $display("FAIL single_edge1 start=%b count=%0d exp start=0 count=1", uart_start, count);
      end
      tick();
      checks++;
      if (uart_start !== 1'b1 || uart_data !== 8'h55 || busy !== 1'b1) begin
         failures++; $display("FAIL single_launch start=%b data=%h busy=%b exp 1/55/1", uart_start, uart_data, busy);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec() || uart_start !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL single_wait cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
         end
      end
      uart_tx_done = 1; tick();
      checks++;
      if (busy !== 1'b0 || uart_data !== 8'h55 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL single_done busy=%b data=%h got=%h exp=%h", busy, uart_data, dut_vec, exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      tx_auto = 1; dly_lo = 3; dly_hi = 30; n = 0;
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1; wr_data = 8'(i); tick();
         if (uart_start === 1'b1) n++;
      end
      wr_en = 0;
      for (int i = 0; i < 500 && (m_busy || m_fifo.size() != 0); i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL b2b_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
         end
         if (uart_start === 1'b1) begin
            n++;
            checks++;
            if (n > 1 && cyc - last_done_cyc != 2) begin
               failures++; $display("FAIL b2b_gap start_cyc=%0d done_cyc=%0d exp gap 2", cyc, last_done_cyc);
            end
         end
      end
      checks++;
      if (got.size() != 5) begin
         failures++; $display("FAIL b2b_launches got=%0d exp=5", got.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== 8'(i + 1)) begin
               failures++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, got[i], 8'(i + 1));
            end
         end
      end
   endtask

   task automatic test_fill_overflow();
      logic [7:0] sent[$];
      do_reset();
      for (int i = 0; i < 17; i++) begin
         wr_en = 1; wr_data = 8'($urandom); sent.push_back(wr_data); tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL fill_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
         end
      end
      wr_en = 0; tick();
      checks++;
      if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
         failures++; $display("FAIL fill_full count=%0d full=%b ovf=%b exp 16/1/0", count, full, overflow);
      end
      wr_en = 1; wr_data = 8'hEE; tick();
      checks++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         failures++; $display("FAIL fill_overflow ovf=%b count=%0d exp 1/16", overflow, count);
      end
      clr_overflow = 1; tick();
      checks++;
      if (overflow !== 1'b1) begin
         failures++; $display("FAIL ovf_set_wins ovf=%b exp=1", overflow);
      end
      wr_en = 0; tick(); clr_overflow = 0;
      checks++;
      if (overflow !== 1'b0 || count !== 5'd16) begin
         failures++; $display("FAIL ovf_clear ovf=%b count=%0d exp 0/16", overflow, count);
      end
      tx_auto = 1; dly_lo = 1; dly_hi = 4; uart_tx_done = 1;
      for (int i = 0; i < 600 && (m_busy || m_fifo.size() != 0); i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL fill_drain cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
         end
      end
      checks++;
      if (got.size() != 17) begin
         failures++; $display("FAIL fill_count got=%0d exp=17", got.size());
      end else begin
         for (int i = 0; i < 17; i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
               failures++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, got[i], sent[i]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      int idx = 0;
      do_reset();
      tx_auto = 1; dly_lo = 1; dly_hi = 6;
      for (int i = 0; i < 3000 && (idx < 40 || m_busy || m_fifo.size() != 0); i++) begin
         wr_en = (idx < 40) && ($urandom_range(3, 0) != 0);
         wr_data = 8'(idx);
         if (wr_en && m_fifo.size() != DEPTH) idx++;
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL wrap_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
         end
      end
      wr_en = 0;
      checks++;
      if (got.size() != 40 || empty !== 1'b1) begin
         failures++; $display("FAIL wrap_done launched=%0d empty=%b exp 40/1", got.size(), empty);
      end else begin
         for (int i = 0; i < 40; i++) begin
            checks++;
            if (got[i] !== 8'(i)) begin
               failures++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, got[i], 8'(i));
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         wr_en        = ($urandom_range(2, 0) == 0);
         wr_data      = 8'($urandom);
         clr_overflow = ($urandom_range(15, 0) == 0);
         uart_tx_done = ($urandom_range(6, 0) == 0);
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
         end
      end
      wr_en = 0; clr_overflow = 0;
   endtask

`ifdef UART_TX_BUF_TIMEOUT_EN
   task automatic test_timeout();
      int s1 = -1, s2 = -1;
      do_reset();
      wr_en = 1; wr_data = 8'hA5; tick();
      wr_data = 8'hB6; tick(); wr_en = 0;
      if (uart_start === 1'b1) s1 = cyc;
      for (int i = 0; i < 200 && s2 < 0; i++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL timeout_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
         end
         if (uart_start === 1'b1) s2 = cyc;
      end
      checks++;
      if (s1 < 0 || s2 - s1 != TO + 1 || tx_timeout !== 1'b1 || uart_data !== 8'hB6) begin
         failures++; $display("FAIL timeout_relaunch gap=%0d to=%b data=%h exp gap=%0d to=1 data=b6",
                              s2 - s1, tx_timeout, uart_data, TO + 1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill_overflow();
      test_wrap();
      test_random();
`ifdef UART_TX_BUF_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
